// File: rtl/wb_issue_scheduler_pkg.sv
// rtl/wb_issue_scheduler_pkg.sv - shared widths, latencies and writer-class encoding
package wb_issue_scheduler_pkg;

  localparam int REG_ADDR_DEF = 5;
  localparam int ALU_WB_DEF   = 2;
  localparam int MUL_WB_DEF   = 6;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MUL = 1'b1;

endpackage

// File: rtl/wb_issue_scheduler_slot_shifter.sv
// rtl/wb_issue_scheduler_slot_shifter.sv - write-port reservation shift register
// Slot 0 is the write-back happening this cycle; PROBE_IDX exposes one future slot.
module wb_slot_shifter #(
  parameter int DEPTH     = 6,
  parameter int AW        = 5,
  parameter int PROBE_IDX = 2,
  parameter int IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          set_cls,
  input  logic [AW-1:0] set_rd,
  output logic          probe_busy,
  output logic          slot0_en,
  output logic          slot0_cls,
  output logic [AW-1:0] slot0_rd
);

  logic [DEPTH-1:0]         resv_q, resv_d;
  logic [DEPTH-1:0]         cls_q, cls_d;
  logic [DEPTH-1:0][AW-1:0] dst_q, dst_d;

  always_comb begin
    resv_d = resv_q >> 1;
    cls_d  = cls_q >> 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      dst_d[i] = dst_q[i+1];
    end
    dst_d[DEPTH-1] = '0;
    // The new reservation lands in the post-shift slot, so it sees this edge's shift.
    for (int i = 0; i < DEPTH; i++) begin
      if (set_en && (set_idx == IW'(i))) begin
        resv_d[i] = 1'b1;
        cls_d[i]  = set_cls;
        dst_d[i]  = set_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resv_q <= '0;
      cls_q  <= '0;
      dst_q  <= '0;
    end else begin
      resv_q <= resv_d;
      cls_q  <= cls_d;
      dst_q  <= dst_d;
    end
  end

  generate
    if (PROBE_IDX < DEPTH) begin : g_probe
      assign probe_busy = resv_q[PROBE_IDX];
    end else begin : g_no_probe
      assign probe_busy = 1'b0;
    end
  endgenerate

  assign slot0_en  = resv_q[0];
  assign slot0_cls = cls_q[0];
  assign slot0_rd  = dst_q[0];

endmodule

// File: rtl/wb_issue_scheduler.sv
// rtl/wb_issue_scheduler.sv - issue control sharing one regfile write port between ALU and multiply pipe
// MUL_FWD_EN: a multiply result written back this cycle satisfies RAW consumers in the same cycle.
module wb_issue_scheduler
  import wb_issue_scheduler_pkg::*;
#(
  parameter int REG_ADDR = REG_ADDR_DEF,
  parameter int ALU_WB   = ALU_WB_DEF,
  parameter int MUL_WB   = MUL_WB_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic                dec_is_mul,
  input  logic                dec_regwrite,
  input  logic [REG_ADDR-1:0] dec_rs,
  input  logic [REG_ADDR-1:0] dec_rt,
  input  logic                dec_uses_rt,
  input  logic [REG_ADDR-1:0] dec_rd,
  input  logic                flush,
  output logic                issue_ready,
  output logic                issue_alu,
  output logic                issue_mul,
  output logic                wb_en,
  output logic                wb_sel,
  output logic [REG_ADDR-1:0] wb_rd
);

  localparam int NREG = 1 << REG_ADDR;
  localparam int IW   = $clog2(MUL_WB);
  localparam logic [IW-1:0] ALU_IDX = IW'(ALU_WB - 1);
  localparam logic [IW-1:0] MUL_IDX = IW'(MUL_WB - 1);

  logic [NREG-1:0] pending_q, pending_d;
  logic            alu_slot_busy;
  logic            eff_wr;
  logic            struct_conf;
  logic            raw_rs, raw_rt, waw;
  logic            ready_raw;
  logic            set_en;
  logic [IW-1:0]   set_idx;
  logic            set_cls;
  logic            mul_wb_now;

  assign eff_wr     = dec_regwrite && (dec_rd != '0);
  assign mul_wb_now = wb_en && (wb_sel == WB_MUL);

  // A multiply would probe slot MUL_WB, which lies beyond the vector and is never busy.
  assign struct_conf = eff_wr && !dec_is_mul && alu_slot_busy;

`ifdef MUL_FWD_EN
  assign raw_rs = pending_q[dec_rs] && !(mul_wb_now && (wb_rd == dec_rs));
  assign raw_rt = dec_uses_rt && pending_q[dec_rt] && !(mul_wb_now && (wb_rd == dec_rt));
`else
  assign raw_rs = pending_q[dec_rs];
  assign raw_rt = dec_uses_rt && pending_q[dec_rt];
`endif
  assign waw = eff_wr && pending_q[dec_rd];

  assign ready_raw   = !(struct_conf || raw_rs || raw_rt || waw);
  assign issue_ready = !reset || ready_raw;
  assign issue_alu   = reset && dec_valid && !flush && ready_raw && !dec_is_mul;
  assign issue_mul   = reset && dec_valid && !flush && ready_raw && dec_is_mul;

  assign set_en  = (issue_alu || issue_mul) && eff_wr;
  assign set_idx = dec_is_mul ? MUL_IDX : ALU_IDX;
  assign set_cls = dec_is_mul ? WB_MUL : WB_ALU;

  wb_slot_shifter #(
    .DEPTH     (MUL_WB),
    .AW        (REG_ADDR),
    .PROBE_IDX (ALU_WB),
    .IW        (IW)
  ) u_slots (
    .clk        (clk),
    .resetn     (reset),
    .set_en     (set_en),
    .set_idx    (set_idx),
    .set_cls    (set_cls),
    .set_rd     (dec_rd),
    .probe_busy (alu_slot_busy),
    .slot0_en   (wb_en),
    .slot0_cls  (wb_sel),
    .slot0_rd   (wb_rd)
  );

  always_comb begin
    pending_d = pending_q;
    if (mul_wb_now) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue_mul && eff_wr) begin
      pending_d[dec_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_wb_issue_scheduler.sv
// tb/tb_wb_issue_scheduler.sv - directed self-checking bench for wb_issue_scheduler
module tb_wb_issue_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_is_mul, dec_regwrite, dec_uses_rt, flush;
  logic [4:0] dec_rs, dec_rt, dec_rd;
  logic       issue_ready, issue_alu, issue_mul, wb_en, wb_sel;
  logic [4:0] wb_rd;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic any_wb;

  always #5 clk = ~clk;

  wb_issue_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_is_mul   (dec_is_mul),
    .dec_regwrite (dec_regwrite),
    .dec_rs       (dec_rs),
    .dec_rt       (dec_rt),
    .dec_uses_rt  (dec_uses_rt),
    .dec_rd       (dec_rd),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .issue_alu    (issue_alu),
    .issue_mul    (issue_mul),
    .wb_en        (wb_en),
    .wb_sel       (wb_sel),
    .wb_rd        (wb_rd)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic mul, input logic rw,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd);
    dec_valid    = v;
    dec_is_mul   = mul;
    dec_regwrite = rw;
    dec_rs       = rs;
    dec_rt       = rt;
    dec_uses_rt  = urt;
    dec_rd       = rd;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd3);
    tick();
    tick();
    #1;
    chk("rst_issue_alu", int'(issue_alu), 0);
    chk("rst_issue_mul", int'(issue_mul), 0);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_issue_ready", int'(issue_ready), 1);

    reset = 1'b1;
    #1;
    chk("post_rst_issue_alu", int'(issue_alu), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("alu_wb_early", int'(wb_en), 0);
    tick();
    #1;
    chk("alu_wb_en", int'(wb_en), 1);
    chk("alu_wb_sel", int'(wb_sel), 0);
    chk("alu_wb_rd", int'(wb_rd), 3);
    idle(8);

    // Structural conflict: ALU four cycles after a multiply.
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd4);
    #1;
    chk("sc_issue_mul", int'(issue_mul), 1);
    tick();
    idle(3);
    drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5);
    #1;
    chk("sc_ready_c4", int'(issue_ready), 0);
    chk("sc_alu_c4", int'(issue_alu), 0);
    tick();
    #1;
    chk("sc_alu_c5", int'(issue_alu), 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("sc_wb6_en", int'(wb_en), 1);
    chk("sc_wb6_sel", int'(wb_sel), 1);
    chk("sc_wb6_rd", int'(wb_rd), 4);
    tick();
    #1;
    chk("sc_wb7_en", int'(wb_en), 1);
    chk("sc_wb7_sel", int'(wb_sel), 0);
    chk("sc_wb7_rd", int'(wb_rd), 5);
    idle(8);

    // RAW on a multiply destination.
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 1'b0, 5'd8);
    #1;
    chk("raw_ready_c1", int'(issue_ready), 0);
    cyc = -1;
    for (int c = 1; c <= 20 && cyc < 0; c++) begin
      #1;
      if (issue_alu) cyc = c;
      tick();
    end
`ifdef MUL_FWD_EN
    chk("raw_issue_cycle", cyc, 6);
`else
    chk("raw_issue_cycle", cyc, 7);
`endif
    idle(8);

    // RAW on rt only.
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd12);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd1, 5'd12, 1'b1, 5'd0);
    #1;
    chk("rawrt_ready_c1", int'(issue_ready), 0);
    dec_uses_rt = 1'b0;
    #1;
    chk("rawrt_unused_ready", int'(issue_ready), 1);
    idle(10);

    // WAW: forwarding never shortens this wait.
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9);
    tick();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd9);
    cyc = -1;
    for (int c = 1; c <= 20 && cyc < 0; c++) begin
      #1;
      if (issue_alu) cyc = c;
      tick();
    end
    chk("waw_issue_cycle", cyc, 7);
    idle(8);

    // rd = 0 reserves nothing.
    drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("r0_issue_mul", int'(issue_mul), 1);
    tick();
    any_wb = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      any_wb = any_wb | wb_en;
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd10);
    #1;
    chk("r0_alu_c4", int'(issue_alu), 1);
    any_wb = any_wb | wb_en;
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    any_wb = any_wb | wb_en;
    chk("r0_no_wb", int'(any_wb), 0);
    tick();
    #1;
    chk("r0_alu_wb_rd", int'(wb_rd), 10);
    chk("r0_alu_wb_en", int'(wb_en), 1);
    idle(8);

    // Six back-to-back multiplies.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'(i + 1));
      #1;
      chk($sformatf("str_issue_%0d", i), int'(issue_mul), 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("str_wb_en_%0d", i), int'(wb_en), 1);
      chk($sformatf("str_wb_rd_%0d", i), int'(wb_rd), i + 1);
      tick();
    end
    idle(8);

    // Same stream with the third multiply flushed.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'(i + 11));
      flush = (i == 2);
      #1;
      chk($sformatf("fl_issue_%0d", i), int'(issue_mul), (i == 2) ? 0 : 1);
      tick();
    end
    flush = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 5'd13, 5'd0, 1'b0, 5'd0);
    #1;
    chk("fl_no_pending", int'(issue_alu), 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) #1;
      chk($sformatf("fl_wb_en_%0d", i), int'(wb_en), (i == 2) ? 0 : 1);
      chk($sformatf("fl_wb_rd_%0d", i), int'(wb_rd), (i == 2) ? 0 : i + 11);
      tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
